// File: rtl/uart_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
package uart_pkg;

    localparam logic [31:0] DATA_OFS   = 32'd0;
    localparam logic [31:0] STATUS_OFS = 32'd4;

    localparam int unsigned ST_FULL  = 0;
    localparam int unsigned ST_EMPTY = 1;
    localparam int unsigned ST_BUSY  = 2;
    localparam int unsigned ST_OVF   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a combinational head output.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a push on a full FIFO is still accepted.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: DATA/STATUS decode, byte FIFO and 8N1 serializer.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [31:0] ADDR,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        sel,
    output logic        tx,
    output logic        busy
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    tx_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          ovf_q;

    logic          data_hit, status_hit, bit_end;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic          unused_wd;

    assign data_hit   = (ADDR == BASE_ADDR + DATA_OFS);
    assign status_hit = (ADDR == BASE_ADDR + STATUS_OFS);
    assign sel        = data_hit || status_hit;
    assign unused_wd  = ^WD[31:8];

    assign bit_end   = (cnt_q == CNT_MAX);
    assign fifo_push = WE && data_hit;
    assign fifo_pop  = !fifo_empty &&
                       ((state_q == IDLE) || (state_q == STOP && bit_end));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (WD[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Serializer: transitions only at bit boundaries, so the counter restarts on every state entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            cnt_q <= (state_q == IDLE || bit_end) ? '0 : cnt_q + CW'(1);
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= START;
                        shift_q <= fifo_dout;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_q   <= DATA;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (!fifo_empty) begin
                            state_q <= START;
                            shift_q <= fifo_dout;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Sticky overflow: a DATA store that the FIFO could not take.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (WE && status_hit && WD[ST_OVF]) begin
            ovf_q <= 1'b0;
        end else if (fifo_push && fifo_full && !fifo_pop) begin
            ovf_q <= 1'b1;
        end
    end

    always_comb begin
        RD = '0;
        if (status_hit) begin
            RD[ST_FULL]  = fifo_full;
            RD[ST_EMPTY] = fifo_empty;
            RD[ST_BUSY]  = (state_q != IDLE);
            RD[ST_OVF]   = ovf_q;
        end
    end

    assign tx   = tx_q;
    assign busy = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-level reference model plus directed literal checks.
module tb_mmio_uart_tx;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned FRAME   = 10 * CLK_DIV;
    localparam logic [31:0] BASE    = 32'hFFFF_0000;
    localparam logic [31:0] STAT    = BASE + 32'd4;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        WE    = 1'b0;
    logic [31:0] ADDR  = 32'd0;
    logic [31:0] WD    = 32'd0;
    logic [31:0] RD;
    logic        sel, tx, busy;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .WE    (WE),
        .ADDR  (ADDR),
        .WD    (WD),
        .RD    (RD),
        .sel   (sel),
        .tx    (tx),
        .busy  (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    endtask

    // Model: a byte queue and the position within the current frame.
    logic [7:0] q[$];
    logic [7:0] m_byte   = 8'd0;
    bit         m_active = 1'b0;
    int         m_cyc    = 0;
    bit         m_ovf    = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_active = 1'b0;
            m_cyc    = 0;
            m_ovf    = 1'b0;
        end else begin
            if (m_active) begin
                if (m_cyc == FRAME - 1) begin
                    if (q.size() > 0) begin
                        m_byte = q.pop_front();
                        m_cyc  = 0;
                    end else begin
                        m_active = 1'b0;
                    end
                end else begin
                    m_cyc++;
                end
            end else if (q.size() > 0) begin
                m_byte   = q.pop_front();
                m_active = 1'b1;
                m_cyc    = 0;
            end
            if (WE && ADDR == BASE) begin
                if (q.size() < DEPTH) q.push_back(WD[7:0]);
                else m_ovf = 1'b1;
            end
            if (WE && ADDR == STAT && WD[3]) m_ovf = 1'b0;
        end
    end

    function automatic logic exp_tx();
        int b;
        if (!m_active) return 1'b1;
        b = m_cyc / CLK_DIV;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_byte[b-1];
    endfunction

    function automatic logic [31:0] exp_status();
        return {28'd0, m_ovf, m_active, (q.size() == 0), (q.size() == DEPTH)};
    endfunction

    always @(negedge clk) begin
        chk("tx", 32'(tx), 32'(exp_tx()));
        chk("busy", 32'(busy), 32'(m_active || q.size() != 0));
        chk("sel", 32'(sel), 32'(ADDR == BASE || ADDR == STAT));
        chk("rd", RD, (ADDR == STAT) ? exp_status() : 32'd0);
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        WE = 1'b1; ADDR = a; WD = d;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        WE = 1'b0; ADDR = 32'd0; WD = 32'd0;
    endtask

    task automatic rd_check(input string nm, input logic [31:0] a, input logic [31:0] expv);
        ADDR = a;
        #1;
        chk(nm, RD, expv);
    endtask

    task automatic drain(input int maxc);
        bit done = 1'b0;
        for (int c = 0; c < maxc && !done; c++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        chk("drain_busy", 32'(busy), 32'd0);
    endtask

    logic [9:0] pat55 = 10'b10_1010_1010;

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        rd_check("status_after_reset", STAT, 32'h2);
        chk("tx_reset", 32'(tx), 32'd1);
        chk("busy_reset", 32'(busy), 32'd0);
        idle();

        // Single byte 0x55: start bit one cycle after the write edge, 40 cycles total.
        wr(BASE, 32'hABCD_0055);
        idle();
        @(negedge clk) chk("pre_start_tx", 32'(tx), 32'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk) chk("frame55_tx", 32'(tx), 32'(pat55[i/4]));
        end
        @(negedge clk) chk("busy_after_frame", 32'(busy), 32'd0);

        // Back-to-back frames 0x01 then 0x80.
        wr(BASE, 32'h01);
        wr(BASE, 32'h80);
        idle();
        for (int j = 0; j <= 80; j++) begin
            @(negedge clk);
            if (j == 0)  chk("b2b_start1", 32'(tx), 32'd0);
            if (j == 39) chk("b2b_stop1", 32'(tx), 32'd1);
            if (j == 40) chk("b2b_start2", 32'(tx), 32'd0);
            if (j == 44) chk("b2b_bit0", 32'(tx), 32'd0);
            if (j == 72) chk("b2b_bit7", 32'(tx), 32'd1);
            if (j == 80) chk("b2b_done", 32'(busy), 32'd0);
        end

        // Overflow: six writes into a four-entry FIFO with one pop.
        for (int i = 0; i < 6; i++) wr(BASE, 32'h10 + 32'(i));
        idle();
        rd_check("ovf_status", STAT, 32'hD);
        wr(STAT, 32'h8);
        idle();
        rd_check("ovf_cleared", STAT, 32'h5);
        drain(400);

        // Decode exactness.
        rd_check("dec_rd8", BASE + 32'd8, 32'd0);
        chk("dec_sel8", 32'(sel), 32'd0);
        rd_check("dec_rd1", BASE + 32'd1, 32'd0);
        chk("dec_sel1", 32'(sel), 32'd0);
        rd_check("data_rd", BASE, 32'd0);
        chk("data_sel", 32'(sel), 32'd1);
        wr(BASE + 32'd8, 32'h77);
        idle();
        rd_check("dec_wr8_status", STAT, 32'h2);
        chk("stat_sel", 32'(sel), 32'd1);

        // Full FIFO plus push on the STOP->START pop edge.
        wr(BASE, 32'hA0);
        wr(BASE, 32'hB1);
        wr(BASE, 32'hC2);
        wr(BASE, 32'hD3);
        wr(BASE, 32'hE4);
        idle();
        rd_check("fill_status", STAT, 32'h5);
        repeat (35) @(posedge clk);
        wr(BASE, 32'hF5);
        idle();
        rd_check("fullpop_status", STAT, 32'h5);
        drain(400);

        // Asynchronous reset in the middle of a frame.
        wr(BASE, 32'h3C);
        wr(BASE, 32'h5A);
        idle();
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        rd_check("rst_status", STAT, 32'h2);
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_tx", 32'(tx), 32'd1);
        rd_check("post_rst_status", STAT, 32'h2);
        ADDR = 32'd0;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the single-cycle core's data-memory bus, downstream of the datapath. It consumes the datapath's store traffic (MemWrite, ALUResult as address, WriteData) and returns a combinational read word for the result mux. Stored bytes are buffered in a small FIFO and serialized as 8N1 frames on a `tx` pin. It gives the processor a debug and console output path without stalling the core.

## Interface
- `CLK_DIV`, 868: clock cycles per UART bit. Must be ≥ 2.
- `FIFO_DEPTH`, 8: byte FIFO entries. Must be a power of two, ≥ 2.
- `BASE_ADDR`, 32'hFFFF_0000: byte address of the DATA register. STATUS is at BASE_ADDR+4.

Ports:
- `clk`  in  1  core clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `WE`  in  1  store strobe (MemWrite).
- `ADDR`  in  32  byte address (ALUResult).
- `WD`  in  32  store data (WriteData).
- `RD`  out  32  combinational read data.
- `sel`  out  1  combinational; high when ADDR is BASE_ADDR or BASE_ADDR+4. The datapath uses it to pick RD over data memory.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high while FIFO is non-empty or a frame is in flight.

## Operation
- **DATA write** (WE, ADDR==BASE_ADDR): push WD[7:0]. WD[31:8] are ignored.
  - If the FIFO is full and no pop happens this cycle, the byte is dropped and sticky `overflow` is set.
  - A push and a pop in the same cycle on a full FIFO: the push is accepted and the count is unchanged.
- **STATUS write** (WE, ADDR==BASE_ADDR+4): WD[3]=1 clears `overflow`. All other bits are ignored.
- **STATUS read**: bit0 full, bit1 empty, bit2 tx_busy (FSM ≠ IDLE), bit3 overflow. Bits [31:4] read 0.
- **DATA read**: returns 0.
- **Unmatched addresses**: RD=0, sel=0, writes ignored. Address decode is exact; there is no aliasing.
- **Transmitter FSM**:
  - IDLE → START when the FIFO is non-empty. The head byte is popped into a shift register on that edge.
  - START: tx=0 for CLK_DIV cycles → DATA.
  - DATA: 8 bits, LSB first, CLK_DIV cycles each. A 3-bit bit index goes 0..7; after bit 7 → STOP.
  - STOP: tx=1 for CLK_DIV cycles, then → START if the FIFO is non-empty (pop on the same edge), else → IDLE. Frames go back to back with no extra idle cycle.
- **Baud counter**: counts 0..CLK_DIV-1. It is cleared on every state entry and wraps to 0 on each bit boundary.
- **FIFO pointers**: log2(FIFO_DEPTH)+1 bits with wrap-around. Full when the pointers differ only in the MSB; empty when they are equal.

## Timing
- **Reset values**: tx=1, busy=0, FSM=IDLE, FIFO empty, overflow=0, counters 0.
- **Reset mid-frame**: tx goes to 1 immediately (asynchronous) and FIFO contents are discarded.
- **RD and sel**: combinational from ADDR and current state, valid in the same cycle. This matches the single-cycle load path.
- **First-byte latency**: a write on edge k makes empty=0 after edge k. The pop happens on edge k+1, and tx falls after edge k+1.
- **Frame length**: exactly 10·CLK_DIV cycles.
- **Read of STATUS in the same cycle as a DATA write**: returns pre-edge values.

## Structure
- **Package `uart_pkg`**:
  - DATA_OFS=0, STATUS_OFS=4.
  - Status bit indices: ST_FULL=0, ST_EMPTY=1, ST_BUSY=2, ST_OVF=3.
  - FSM state enum: IDLE, START, DATA, STOP (2 bits).
- **Sub-module `sync_fifo`**: parameters WIDTH, DEPTH; ports clk, reset, push, pop, din, dout, full, empty. dout is a combinational head. The top level holds the decode, the FSM, the baud counter, and the shift register.

## Test plan
Run with CLK_DIV=4 and FIFO_DEPTH=4.
- **Reset**: assert reset mid-frame → tx=1 and busy=0 within the same cycle; STATUS read = 32'h2.
- **Single byte**: write 32'hABCD_0055 to DATA → tx sequence 0,1,0,1,0,1,0,1,0,1, each held 4 cycles. Start bit begins 1 cycle after the write edge. Total 40 cycles, then busy=0.
- **Back to back**: write 8'h01 and then 8'h80 on consecutive cycles → two frames with no idle gap between the stop bit and the next start bit.
- **Overflow**:
  - Write 6 bytes in 6 consecutive cycles → first byte popped at cycle 2; one byte dropped; STATUS bit3=1.
  - Write STATUS with 32'h8 → bit3=0.
- **Decode**: read BASE_ADDR+8 → sel=0, RD=0. Write BASE_ADDR+8 → FIFO unchanged. Read BASE_ADDR+4 → sel=1.
- **Full + pop**: fill the FIFO to 4 while in STOP of a prior frame, then push on the pop edge → byte accepted, overflow stays 0.
